sigma_delta_pipe: RTL
=====================

# sigma_delta_pipe

Parametrised, pipelined successor to the single-pixel sigma-delta updater. It takes one pixel per accepted beat with its stored background and variance, and returns the updated background, updated variance and a per-pixel motion flag. It sits between the frame-memory read port and the write-back/mask path of the motion detector, with valid/ready flow control on both sides. It adds configurable pixel width, a variance multiplier N, variance clamping and an init-frame mode.

## Interface
- PIX_W, 8, pixel/background/variance width
- N_MULT, 2, variance target multiplier (target = N_MULT*diff), 1..15
- VAR_STEP, 2, variance increment/decrement per update
- VAR_MIN, 2, variance floor; also reset/init value
- RATE_LOG2, 2, update-rate exponent (used only with SIGMA_DELTA_RATE_EN)

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  pipeline accepts beat
- in_sof  in  1  beat is first pixel of a frame
- in_init  in  1  beat belongs to an initialisation frame
- curr_pixel  in  PIX_W  current pixel
- background  in  PIX_W  stored background
- variance  in  PIX_W  stored variance
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_sof  out  1  in_sof delayed with its beat
- background_next  out  PIX_W  updated background
- variance_next  out  PIX_W  updated variance
- motion  out  1  pixel classified as foreground

## Operation
- Beat accepted when in_valid && in_ready. Stage 1 registers inputs and diff = |curr_pixel - background|. Stage 2 computes and registers results.
- Effective variance v = max(variance, VAR_MIN).
- Normal beat (in_init=0, update enabled):
  - background_next = background+1 if pixel>background (saturate at 2^PIX_W-1); background-1 if pixel<background (saturate at 0); else unchanged.
  - t = N_MULT*diff, computed in PIX_W+4 bits, saturated to 2^PIX_W-1.
  - If diff==0: variance_next = v. Else if t>v: v+VAR_STEP, saturating at 2^PIX_W-1. Else if t<v: v-VAR_STEP, floored at VAR_MIN. Else v.
  - motion = (diff > v). Uses pre-update values.
- Init beat (in_init=1): background_next = curr_pixel, variance_next = VAR_MIN, motion = 0. Always applies, regardless of rate gating.
- Update disabled (rate gating): background_next = background, variance_next = v, motion still computed.

## Timing
- Global advance = !out_valid || out_ready; in_ready = advance. Both stages shift together; bubbles are not compressed.
- Latency: beat accepted at cycle k appears at out_valid in cycle k+2 if unstalled.
- With out_valid=1 && out_ready=0, all outputs hold stable and in_ready=0.
- Throughput: 1 beat/cycle with out_ready held high.
- Reset (asynchronous, any time, including mid-stream): both stages invalid, out_valid=0, out_sof=0, motion=0, background_next=0, variance_next=VAR_MIN, frame counter=0. In-flight beats are discarded. in_ready=1 during reset.
- in_sof and in_init are sampled only on accepted beats.

## Configuration
- Macro SIGMA_DELTA_RATE_EN.
- Defined: RATE_LOG2-bit frame counter, starting at 0.
  - On each accepted in_sof beat, update_frame <= (cnt==0) and cnt <= cnt+1 (wraps).
  - The sof beat itself uses (cnt==0) directly; later beats in the frame use update_frame.
  - Frames 0, 4, 8, … update (RATE_LOG2=2); the others are gated.
  - Init frames also advance the counter.
- Undefined: counter absent; every beat updates.

## Test plan
- Reset then single beat pixel=100, bg=90, var=4, N=2 → two cycles later: out_valid=1, background_next=91, variance_next=6 (t=20>4), motion=1.
- Saturation: pixel=255, bg=255, var=255 → bg_next=255, var_next=255, motion=0. Pixel=0, bg=1, var=0 → bg_next=0, var clamped to 2, t=2 → var_next=2, motion=0.
- Init beat: in_init=1, pixel=37, bg=200, var=90 → bg_next=37, var_next=2, motion=0.
- Backpressure: stream 8 beats, hold out_ready=0 for 5 cycles mid-stream → in_ready=0, outputs stable, no beat lost or duplicated, order preserved.
- Async reset asserted while 2 beats are in flight → out_valid=0 immediately, and no stale beat appears after release.
- With SIGMA_DELTA_RATE_EN and RATE_LOG2=2: 5 frames of pixel=50, bg=40 → frames 0 and 4 give bg_next=41; frames 1–3 give bg_next=40 and motion=1.

Source files
------------

// File: rtl/sigma_delta_pipe_if.sv
// Beat-level interface of sigma_delta_pipe: input beat (pixel, background, variance)
// toward the pipeline, updated result beat back out. Both sides use valid/ready.
interface sigma_delta_pipe_if #(
  parameter int unsigned PIX_W = 8
);
  // A beat moves on a side only in a cycle where valid && ready; the producer holds
  // valid and data stable until that happens, and ready never depends on valid.
  logic             in_valid;
  logic             in_ready;
  logic             in_sof;
  logic             in_init;
  logic [PIX_W-1:0] curr_pixel;
  logic [PIX_W-1:0] background;
  logic [PIX_W-1:0] variance;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic [PIX_W-1:0] background_next;
  logic [PIX_W-1:0] variance_next;
  logic             motion;

  modport master (
    output in_valid, in_sof, in_init, curr_pixel, background, variance, out_ready,
    input  in_ready, out_valid, out_sof, background_next, variance_next, motion
  );

  modport slave (
    input  in_valid, in_sof, in_init, curr_pixel, background, variance, out_ready,
    output in_ready, out_valid, out_sof, background_next, variance_next, motion
  );
endinterface

// File: rtl/sigma_delta_pipe.sv
// Two-stage sigma-delta background/variance updater with motion flag.
// Optional frame-rate gating of updates is enabled by defining SIGMA_DELTA_RATE_EN.
module sigma_delta_pipe #(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned N_MULT    = 2,
  parameter int unsigned VAR_STEP  = 2,
  parameter int unsigned VAR_MIN   = 2,
  parameter int unsigned RATE_LOG2 = 2
) (
  input logic                clk,
  input logic                rst_n,
  sigma_delta_pipe_if.slave  bus
);
  localparam logic [PIX_W-1:0] PIX_MAX = '1;
  localparam logic [PIX_W-1:0] VMIN    = PIX_W'(VAR_MIN);
  localparam logic [PIX_W-1:0] VSTEP   = PIX_W'(VAR_STEP);
  localparam logic [PIX_W:0]   VMIN1   = (PIX_W+1)'(VAR_MIN);
  localparam logic [PIX_W:0]   VSTEP1  = (PIX_W+1)'(VAR_STEP);

  if (N_MULT < 1 || N_MULT > 15 || RATE_LOG2 < 1 || VAR_MIN >= (1 << PIX_W)) begin : g_param_err
    $error("sigma_delta_pipe: parameter out of range");
  end

  // Both stages shift together; a full output that is not taken freezes everything.
  logic advance;
  logic accept;
  logic beat_upd;
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;
  assign accept       = bus.in_valid && advance;

`ifdef SIGMA_DELTA_RATE_EN
  logic [RATE_LOG2-1:0] frame_cnt;
  logic                 update_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt    <= '0;
      update_frame <= 1'b1;
    end else if (accept && bus.in_sof) begin
      update_frame <= (frame_cnt == '0);
      frame_cnt    <= frame_cnt + RATE_LOG2'(1);
    end
  end

  // The sof beat cannot see its own registered decision yet, so it uses the counter.
  assign beat_upd = bus.in_sof ? (frame_cnt == '0) : update_frame;
`else
  assign beat_upd = 1'b1;
`endif

  // Stage 1 registers
  logic             s1_valid, s1_sof, s1_init, s1_upd;
  logic [PIX_W-1:0] s1_pix, s1_bg, s1_var, s1_diff;
  logic [PIX_W-1:0] diff_in;

  assign diff_in = (bus.curr_pixel > bus.background) ? (bus.curr_pixel - bus.background)
                                                      : (bus.background - bus.curr_pixel);

  // Stage 2 datapath
  logic [PIX_W+3:0] t_full;
  logic [PIX_W-1:0] t_sat, v_eff, var_up, var_dn, bg_calc, var_calc;
  logic [PIX_W:0]   v_up_full;
  logic             motion_calc;

  always_comb begin
    t_full      = (PIX_W+4)'(N_MULT) * {4'b0, s1_diff};
    t_sat       = (t_full > {4'b0, PIX_MAX}) ? PIX_MAX : t_full[PIX_W-1:0];
    v_eff       = (s1_var < VMIN) ? VMIN : s1_var;
    v_up_full   = {1'b0, v_eff} + VSTEP1;
    var_up      = v_up_full[PIX_W] ? PIX_MAX : v_up_full[PIX_W-1:0];
    var_dn      = ({1'b0, v_eff} < (VMIN1 + VSTEP1)) ? VMIN : (v_eff - VSTEP);
    motion_calc = (s1_diff > v_eff);
    bg_calc     = s1_bg;
    var_calc    = v_eff;
    if (s1_init) begin
      bg_calc     = s1_pix;
      var_calc    = VMIN;
      motion_calc = 1'b0;
    end else if (s1_upd) begin
      if (s1_pix > s1_bg && s1_bg != PIX_MAX) bg_calc = s1_bg + PIX_W'(1);
      else if (s1_pix < s1_bg && s1_bg != '0) bg_calc = s1_bg - PIX_W'(1);
      if (s1_diff != '0) begin
        if (t_sat > v_eff)      var_calc = var_up;
        else if (t_sat < v_eff) var_calc = var_dn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid            <= 1'b0;
      s1_sof              <= 1'b0;
      s1_init             <= 1'b0;
      s1_upd              <= 1'b0;
      s1_pix              <= '0;
      s1_bg               <= '0;
      s1_var              <= '0;
      s1_diff             <= '0;
      bus.out_valid       <= 1'b0;
      bus.out_sof         <= 1'b0;
      bus.background_next <= '0;
      bus.variance_next   <= VMIN;
      bus.motion          <= 1'b0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sof  <= bus.in_sof;
        s1_init <= bus.in_init;
        s1_upd  <= beat_upd;
        s1_pix  <= bus.curr_pixel;
        s1_bg   <= bus.background;
        s1_var  <= bus.variance;
        s1_diff <= diff_in;
      end
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_sof         <= s1_sof;
        bus.background_next <= bg_calc;
        bus.variance_next   <= var_calc;
        bus.motion          <= motion_calc;
      end
    end
  end
endmodule
